mem_arbiter: RTL

Two-requester memory arbiter sharing the single instruction/data memory port between the I-cache miss path (read-only) and the D-cache miss/write-back path (read/write). Sits between both cache controllers' `mem_*` ports and the memory model; registers the selected request, forwards it, and returns data plus a one-cycle ready pulse to the owner. Round-robin fairness, one outstanding transaction, watchdog timeout with sticky error flag.

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache miss paths onto one memory port.
// Grant registered one cycle after valid; owner sees a one-cycle ready pulse the cycle after memory ready.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ic_req_addr,
  input  logic              ic_req_valid,
  output logic [DATA_W-1:0] ic_req_data,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_req_wr,
  input  logic [DATA_W-1:0] dc_wr_data,
  input  logic              dc_req_valid,
  output logic [DATA_W-1:0] dc_req_data,
  output logic              dc_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_req_wr,
  output logic              mem_req_vaild,
  input  logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_req_ready,
  output logic [1:0]        arb_owner,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

  state_t           state;
  logic             last_dc;
  logic [CNT_W-1:0] wd_cnt;
  logic             grant_dc;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_dc = dc_req_valid && (!ic_req_valid || !last_dc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_dc       <= 1'b0;
      wd_cnt        <= '0;
      mem_req_addr  <= '0;
      mem_wr_data   <= '0;
      mem_req_wr    <= 1'b0;
      mem_req_vaild <= 1'b0;
      ic_req_data   <= '0;
      ic_req_ready  <= 1'b0;
      dc_req_data   <= '0;
      dc_req_ready  <= 1'b0;
      arb_owner     <= 2'b00;
      bus_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ic_req_valid || dc_req_valid) begin
            state         <= BUSY;
            mem_req_vaild <= 1'b1;
            wd_cnt        <= '0;
            last_dc       <= grant_dc;
            if (grant_dc) begin
              mem_req_addr <= dc_req_addr;
              mem_wr_data  <= dc_wr_data;
              mem_req_wr   <= dc_req_wr;
              arb_owner    <= 2'b10;
            end else begin
              mem_req_addr <= ic_req_addr;
              mem_wr_data  <= '0;
              mem_req_wr   <= 1'b0;
              arb_owner    <= 2'b01;
            end
          end
        end
        BUSY: begin
          // Memory ready takes priority over a watchdog expiry in the same cycle.
          if (mem_req_ready || (wd_cnt == TO_LIMIT)) begin
            state         <= RESP;
            mem_req_vaild <= 1'b0;
            if (!mem_req_ready) begin
              bus_err <= 1'b1;
            end
            if (arb_owner[1]) begin
              dc_req_data  <= mem_req_ready ? mem_req_data : ERR_DATA;
              dc_req_ready <= 1'b1;
            end else begin
              ic_req_data  <= mem_req_ready ? mem_req_data : ERR_DATA;
              ic_req_ready <= 1'b1;
            end
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          state        <= IDLE;
          ic_req_ready <= 1'b0;
          dc_req_ready <= 1'b0;
          arb_owner    <= 2'b00;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
